// File: rtl/ctrl_pkg.sv
// Shared constants for the microcode sequencer: control word bit layout,
// opcode encodings, fetch words and the step/control widths.
package ctrl_pkg;

   localparam int STEP_W = 3;
   localparam int CTRL_W = 16;
   localparam logic [STEP_W-1:0] MAX_STEP = 3'd4;

   localparam int BIT_HLT = 15;
   localparam int BIT_MI  = 14;
   localparam int BIT_RI  = 13;
   localparam int BIT_RO  = 12;
   localparam int BIT_IO  = 11;
   localparam int BIT_II  = 10;
   localparam int BIT_AI  = 9;
   localparam int BIT_AO  = 8;
   localparam int BIT_EO  = 7;
   localparam int BIT_SU  = 6;
   localparam int BIT_BI  = 5;
   localparam int BIT_OI  = 4;
   localparam int BIT_CE  = 3;
   localparam int BIT_CO  = 2;
   localparam int BIT_J   = 1;
   localparam int BIT_FI  = 0;

   localparam logic [CTRL_W-1:0] HLT = 16'h8000;
   localparam logic [CTRL_W-1:0] MI  = 16'h4000;
   localparam logic [CTRL_W-1:0] RI  = 16'h2000;
   localparam logic [CTRL_W-1:0] RO  = 16'h1000;
   localparam logic [CTRL_W-1:0] IO  = 16'h0800;
   localparam logic [CTRL_W-1:0] II  = 16'h0400;
   localparam logic [CTRL_W-1:0] AI  = 16'h0200;
   localparam logic [CTRL_W-1:0] AO  = 16'h0100;
   localparam logic [CTRL_W-1:0] EO  = 16'h0080;
   localparam logic [CTRL_W-1:0] SU  = 16'h0040;
   localparam logic [CTRL_W-1:0] BI  = 16'h0020;
   localparam logic [CTRL_W-1:0] OI  = 16'h0010;
   localparam logic [CTRL_W-1:0] CE  = 16'h0008;
   localparam logic [CTRL_W-1:0] CO  = 16'h0004;
   localparam logic [CTRL_W-1:0] J   = 16'h0002;
   localparam logic [CTRL_W-1:0] FI  = 16'h0001;

   localparam logic [CTRL_W-1:0] FETCH_T0 = CO | MI;
   localparam logic [CTRL_W-1:0] FETCH_T1 = RO | II | CE;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: maps (opcode, step, flags) to the control
// word and flags the final step of the instruction.
module microcode_rom
   import ctrl_pkg::*;
(
   input  logic [3:0]        opcode_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              carry_i,
   input  logic              zero_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              last_o
);

   always_comb begin
      ctrl_o = '0;
      last_o = 1'b0;
      if (step_i == 3'd0) begin
         ctrl_o = FETCH_T0;
      end else if (step_i == 3'd1) begin
         ctrl_o = FETCH_T1;
      end else begin
         // HLT never reports a last step; the sequencer latches halt instead.
         unique case (opcode_i)
            OP_LDA: begin
               ctrl_o = (step_i == 3'd2) ? (IO | MI) : (step_i == 3'd3) ? (RO | AI) : '0;
               last_o = (step_i >= 3'd3);
            end
            OP_ADD, OP_SUB: begin
               if (step_i == 3'd2)      ctrl_o = IO | MI;
               else if (step_i == 3'd3) ctrl_o = RO | BI;
               else if (step_i == 3'd4) ctrl_o = (opcode_i == OP_SUB) ? (EO | SU | AI | FI) : (EO | AI | FI);
               last_o = (step_i >= 3'd4);
            end
            OP_STA: begin
               ctrl_o = (step_i == 3'd2) ? (IO | MI) : (step_i == 3'd3) ? (AO | RI) : '0;
               last_o = (step_i >= 3'd3);
            end
            OP_LDI: begin
               ctrl_o = (step_i == 3'd2) ? (IO | AI) : '0;
               last_o = 1'b1;
            end
            OP_JMP: begin
               ctrl_o = (step_i == 3'd2) ? (IO | J) : '0;
               last_o = 1'b1;
            end
            OP_JC: begin
               ctrl_o = (step_i == 3'd2 && carry_i) ? (IO | J) : '0;
               last_o = 1'b1;
            end
            OP_JZ: begin
               ctrl_o = (step_i == 3'd2 && zero_i) ? (IO | J) : '0;
               last_o = 1'b1;
            end
            OP_OUT: begin
               ctrl_o = (step_i == 3'd2) ? (AO | OI) : '0;
               last_o = 1'b1;
            end
            OP_HLT: begin
               ctrl_o = (step_i == 3'd2) ? HLT : '0;
               last_o = (step_i != 3'd2);
            end
            default: begin
               ctrl_o = '0;
               last_o = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/ctrl_seq.sv
// Microstep sequencer: owns the step counter and halt latch, and gates the
// microcode ROM output during reset and halt.
module ctrl_seq
   import ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              clear_n,
   input  logic [3:0]        opcode,
   input  logic              carry_flag,
   input  logic              zero_flag,
   output logic [CTRL_W-1:0] ctrl,
   output logic [STEP_W-1:0] step,
   output logic              halted
);

   logic [STEP_W-1:0] step_q, step_d;
   logic              halted_q, halted_d;
   logic [CTRL_W-1:0] romCtrl;
   logic              romLast;

   microcode_rom uRom (
      .opcode_i (opcode),
      .step_i   (step_q),
      .carry_i  (carry_flag),
      .zero_i   (zero_flag),
      .ctrl_o   (romCtrl),
      .last_o   (romLast)
   );

   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (opcode == OP_HLT && step_q == 3'd2) begin
            halted_d = 1'b1;
         end else if (romLast || step_q >= MAX_STEP) begin
            step_d = '0;
         end else begin
            step_d = step_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         step_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   // Reset forces a quiet bus combinationally so no agent loads while clear_n is low.
   always_comb begin
      if (!clear_n)      ctrl = '0;
      else if (halted_q) ctrl = HLT;
      else               ctrl = romCtrl;
   end

   assign step   = step_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq: fetch/execute words, jumps,
// halt freeze and asynchronous reset behaviour.
module tb_ctrl_seq;

   logic        clk = 1'b0;
   logic        clear_n = 1'b0;
   logic [3:0]  opcode = 4'd0;
   logic        carry_flag = 1'b0;
   logic        zero_flag = 1'b0;
   logic [15:0] ctrl;
   logic [2:0]  step;
   logic        halted;

   int checks = 0;
   int errors = 0;

   ctrl_seq dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .opcode     (opcode),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .ctrl       (ctrl),
      .step       (step),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walks one instruction from T0, expecting the given words, then T0 again.
   task automatic runInstr(input string name, input logic [3:0] op, input int len,
                           input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input logic [15:0] w4);
      logic [15:0] exp [5];
      exp = '{w0, w1, w2, w3, w4};
      opcode = op;
      for (int i = 0; i < len; i++) begin
         checks++;
         if (ctrl !== exp[i] || step !== 3'(i) || halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s T%0d: ctrl=%h step=%0d halted=%b, required ctrl=%h step=%0d halted=0",
                     name, i, ctrl, step, halted, exp[i], i);
         end
         tick();
      end
      checks++;
      if (step !== 3'd0 || ctrl !== 16'h4004) begin
         errors++;
         $display("[TB] FAIL %s end: step=%0d ctrl=%h, required step=0 ctrl=4004", name, step, ctrl);
      end
   endtask

   task automatic test_reset();
      opcode  = 4'b0101;
      clear_n = 1'b0;
      tick();
      checks++;
      if (ctrl !== 16'h0000 || step !== 3'd0 || halted !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_hold: ctrl=%h step=%0d halted=%b, required 0000/0/0", ctrl, step, halted);
      end
      clear_n = 1'b1;
      #1;
      checks++;
      if (ctrl !== 16'h4004 || step !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_release: ctrl=%h step=%0d, required 4004/0", ctrl, step);
      end
      runInstr("ldi", 4'b0101, 3, 16'h4004, 16'h1408, 16'h0A00, 16'h0, 16'h0);
   endtask

   task automatic test_alu();
      runInstr("sub", 4'b0011, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C1);
      runInstr("add", 4'b0010, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281);
      runInstr("lda", 4'b0001, 4, 16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0);
      runInstr("sta", 4'b0100, 4, 16'h4004, 16'h1408, 16'h4800, 16'h2100, 16'h0);
      runInstr("out", 4'b1110, 3, 16'h4004, 16'h1408, 16'h0110, 16'h0, 16'h0);
      runInstr("jmp", 4'b0110, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0, 16'h0);
   endtask

   task automatic test_jumps();
      carry_flag = 1'b0;
      runInstr("jc_false", 4'b0111, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0, 16'h0);
      carry_flag = 1'b1;
      runInstr("jc_true", 4'b0111, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0, 16'h0);
      carry_flag = 1'b0;
      zero_flag  = 1'b1;
      runInstr("jz_true", 4'b1000, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0, 16'h0);
      zero_flag = 1'b0;
      runInstr("jz_false", 4'b1000, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0, 16'h0);
      // Flag flips mid-T2 must reach ctrl without an edge.
      opcode = 4'b1000;
      tick();
      tick();
      zero_flag = 1'b1;
      #1;
      checks++;
      if (ctrl !== 16'h0802 || step !== 3'd2) begin
         errors++;
         $display("[TB] FAIL jz_flag_live: ctrl=%h step=%0d, required 0802/2", ctrl, step);
      end
      zero_flag = 1'b0;
      tick();
   endtask

   task automatic test_undefined();
      runInstr("undef_1010", 4'b1010, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0, 16'h0);
      runInstr("nop", 4'b0000, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0, 16'h0);
   endtask

   task automatic test_mid_reset();
      opcode = 4'b0010;
      tick();
      tick();
      tick();
      checks++;
      if (ctrl !== 16'h1020 || step !== 3'd3) begin
         errors++;
         $display("[TB] FAIL add_t3: ctrl=%h step=%0d, required 1020/3", ctrl, step);
      end
      clear_n = 1'b0;
      #1;
      checks++;
      if (ctrl !== 16'h0000 || step !== 3'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: ctrl=%h step=%0d, required 0000/0", ctrl, step);
      end
      tick();
      checks++;
      if (ctrl !== 16'h0000 || step !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_held_edge: ctrl=%h step=%0d, required 0000/0", ctrl, step);
      end
      clear_n = 1'b1;
      #1;
      checks++;
      if (ctrl !== 16'h4004 || step !== 3'd0) begin
         errors++;
         $display("[TB] FAIL resume_t0: ctrl=%h step=%0d, required 4004/0", ctrl, step);
      end
   endtask

   task automatic test_halt();
      opcode = 4'b1111;
      tick();
      tick();
      checks++;
      if (ctrl !== 16'h8000 || step !== 3'd2 || halted !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hlt_t2: ctrl=%h step=%0d halted=%b, required 8000/2/0", ctrl, step, halted);
      end
      tick();
      checks++;
      if (halted !== 1'b1 || step !== 3'd2 || ctrl !== 16'h8000) begin
         errors++;
         $display("[TB] FAIL hlt_latch: halted=%b step=%0d ctrl=%h, required 1/2/8000", halted, step, ctrl);
      end
      for (int i = 0; i < 10; i++) begin
         opcode     = 4'(i);
         carry_flag = i[0];
         zero_flag  = i[1];
         tick();
         checks++;
         if (halted !== 1'b1 || step !== 3'd2 || ctrl !== 16'h8000) begin
            errors++;
            $display("[TB] FAIL hlt_frozen_%0d: halted=%b step=%0d ctrl=%h, required 1/2/8000", i, halted, step, ctrl);
         end
      end
      clear_n = 1'b0;
      #1;
      checks++;
      if (halted !== 1'b0 || step !== 3'd0 || ctrl !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL hlt_reset: halted=%b step=%0d ctrl=%h, required 0/0/0000", halted, step, ctrl);
      end
      clear_n = 1'b1;
      #1;
      checks++;
      if (halted !== 1'b0 || step !== 3'd0 || ctrl !== 16'h4004) begin
         errors++;
         $display("[TB] FAIL hlt_release: halted=%b step=%0d ctrl=%h, required 0/0/4004", halted, step, ctrl);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_jumps();
      test_undefined();
      test_mid_reset();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Microcode control sequencer for the 8-bit bus CPU. It advances a microstep counter and decodes the instruction register opcode, plus the carry and zero flags, into the 16-bit control word. That control word drives the `load`/`enable` pins of every `reg8` and the other bus agents. It sits directly upstream of the register file, memory, ALU, program counter and output register, and feeds each of them one control word per clock.

## Interface
- Parameters: none. All widths, bit positions and opcodes are fixed in `ctrl_pkg`.
- `clk` in 1: single system clock, rising edge.
- `clear_n` in 1: reset, asynchronous, active-low.
- `opcode` in 4: instruction register bits [7:4].
- `carry_flag` in 1: registered carry flag, from the flags register.
- `zero_flag` in 1: registered zero flag, from the flags register.
- `ctrl` out 16: control word, bit order below.
- `step` out 3: current microstep, 0..4.
- `halted` out 1: CPU stopped by HLT.

## Operation
- Control word bit order: [15] HLT, [14] MI, [13] RI, [12] RO, [11] IO, [10] II, [9] AI, [8] AO, [7] EO, [6] SU, [5] BI, [4] OI, [3] CE, [2] CO, [1] J, [0] FI.
- Fetch microsteps, common to every opcode:
  - T0: CO|MI = 0x4004.
  - T1: RO|II|CE = 0x1408.
- Execute microsteps, by opcode:
  - NOP 0000: T2 = 0. Length 3.
  - LDA 0001: T2 IO|MI, T3 RO|AI. Length 4.
  - ADD 0010: T2 IO|MI, T3 RO|BI, T4 EO|AI|FI. Length 5.
  - SUB 0011: same as ADD, except T4 = EO|SU|AI|FI = 0x02C1. Length 5.
  - STA 0100: T2 IO|MI, T3 AO|RI. Length 4.
  - LDI 0101: T2 IO|AI = 0x0A00. Length 3.
  - JMP 0110: T2 IO|J = 0x0802. Length 3.
  - JC 0111: T2 IO|J if `carry_flag`, else 0. Length 3 either way.
  - JZ 1000: T2 IO|J if `zero_flag`, else 0. Length 3 either way.
  - OUT 1110: T2 AO|OI. Length 3.
  - HLT 1111: T2 HLT = 0x8000.
  - All other opcodes behave as NOP.
- Step sequencing:
  - The step counter increments on each rising edge.
  - On the edge that ends the opcode's last step, it returns to 0.
  - Maximum count is 4; there is no wrap past 4.
- `ctrl` is combinational from `step`, `opcode` and the flags.
  - It is stable for the whole cycle.
  - Consumers sample it on the next rising edge, as `reg8` load does.
- Halt:
  - The edge ending T2 of HLT sets the `halted` register.
  - Once `halted` is set, `step` is frozen at 2 and `ctrl` = 0x8000, regardless of `opcode` or flags.
  - Only reset exits halt.

## Timing
- While `clear_n` is low:
  - `step` = 0 and `halted` = 0.
  - `ctrl` is forced to 0x0000, so there is no spurious load or enable during reset.
- After `clear_n` deasserts:
  - `ctrl` = 0x4004 (T0) immediately.
  - The first rising edge moves to T1.
- Instruction latency: the rising edge that ends the last step both performs the final transfer and starts the next T0.
- Reset assertion mid-instruction, at any step (including while halted):
  - `ctrl` goes to 0 asynchronously and `step` goes to 0.
  - There is no partial completion on a later edge.
- Opcode and flag usage:
  - `opcode` is don't-care during T0/T1. It is used from T2 on, after II loads the IR at the end of T1.
  - Flags are sampled combinationally during T2. A flag change within T2 changes `ctrl` before the edge, and the edge value wins.
- JC/JZ with the flag false still take 3 cycles. The program counter advances only via CE in T1.

## Structure
- `ctrl_pkg`:
  - Control bit index constants and masks (CO, MI, …).
  - The 4-bit opcode constants.
  - The fetch words T0/T1.
  - Step width (3) and control word width (16).
- Sub-module `microcode_rom`, purely combinational:
  - Inputs: (opcode, step, carry, zero).
  - Outputs: (ctrl word, last-step flag).
- `ctrl_seq` holds only the step counter, the `halted` register, the reset forcing and the halt override.

## Test plan
- Reset then LDI (`opcode`=0101): `ctrl` is 0 while reset is low. After release, `ctrl` = 0x4004, 0x1408, 0x0A00 and `step` = 0,1,2, then `step` = 0 again.
- SUB (0011): the five steps give 0x4004, 0x1408, 0x4800, 0x1020, 0x02C1, then `step` returns to 0.
- JC (0111) with `carry_flag`=0: T2 `ctrl` = 0x0000. Repeat with `carry_flag`=1: T2 `ctrl` = 0x0802. Both take 3 cycles.
- HLT (1111): T2 `ctrl` = 0x8000. After that edge, `halted`=1. Then drive 10 more clocks while changing `opcode`: `step` stays 2 and `ctrl` stays 0x8000, until `clear_n` pulses low, which gives `halted`=0, `step`=0 and `ctrl`=0x4004 after release.
- Reset asserted mid-ADD at T3 (`ctrl`=0x1020): `ctrl` drops to 0 and `step` to 0 without waiting for a clock edge. After release, T0 resumes.
- Undefined opcode 1010: 3-step instruction with T2 `ctrl` = 0x0000, then back to T0.
